// File: rtl/fp_wb_pkg.sv
// Shared defaults and types for the FP register-file writeback arbiter.
// Entry layout matches the register-file write port: {rd, data}.
package fp_wb_pkg;

  localparam int WB_WIDTH  = 32;
  localparam int WB_WID_IN = 5;
  localparam int WB_DEPTH  = 4;
  localparam int WB_STARVE = 3;

  typedef struct packed {
    logic [WB_WID_IN-1:0] rd;
    logic [WB_WIDTH-1:0]  data;
  } wb_entry_t;

  // Write source chosen for the current cycle.
  typedef enum logic [1:0] {
    SRC_IDLE  = 2'd0,
    SRC_A     = 2'd1,
    SRC_FORCE = 2'd2,
    SRC_POP   = 2'd3
  } wb_src_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// Synchronous FIFO buffering divide/sqrt results until the write port is free.
// Pointers wrap naturally because DEPTH is a power of two.
module fp_wb_fifo
  import fp_wb_pkg::*;
#(
  parameter type T            = wb_entry_t,
  parameter int  DEPTH        = WB_DEPTH,
  localparam int AW           = $clog2(DEPTH),
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_push,
  input  logic          i_pop,
  input  T              i_data,
  output T              o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  T              r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; stale contents are unreachable once the count is cleared.
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Drives the FP register file's single write port from the FP ALU (priority)
// and a FIFO of divide/sqrt results, with a starvation bound on the FIFO head.
module fp_wb_arbiter
  import fp_wb_pkg::*;
#(
  parameter int  WIDTH  = WB_WIDTH,
  parameter int  WID_IN = WB_WID_IN,
  parameter int  DEPTH  = WB_DEPTH,
  parameter int  STARVE = WB_STARVE,
  localparam int CW     = $clog2(DEPTH) + 1,
  localparam int SW     = $clog2(STARVE + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              A_Valid,
  output logic              A_Ready,
  input  logic [WID_IN-1:0] A_Rd,
  input  logic [WIDTH-1:0]  A_Data,
  input  logic              B_Valid,
  output logic              B_Ready,
  input  logic [WID_IN-1:0] B_Rd,
  input  logic [WIDTH-1:0]  B_Data,
  output logic              Reg_Wr,
  output logic [WID_IN-1:0] Rd_Wr,
  output logic [WIDTH-1:0]  Rd_In,
  output logic [CW-1:0]     Fifo_Count
);

  typedef struct packed {
    logic [WID_IN-1:0] rd;
    logic [WIDTH-1:0]  data;
  } entry_t;

  entry_t            w_head;
  entry_t            w_b_in;
  entry_t            w_sel;
  wb_src_t           w_src;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_write;
  logic [SW-1:0]     w_wait_nxt;
  logic [SW-1:0]     r_wait;
  logic              r_reg_wr;
  logic [WID_IN-1:0] r_rd_wr;
  logic [WIDTH-1:0]  r_rd_in;

  assign w_b_in.rd   = B_Rd;
  assign w_b_in.data = B_Data;
  assign w_push      = B_Valid && !w_full;
  assign B_Ready     = !w_full;
  assign A_Ready     = (w_src != SRC_FORCE);
  assign w_write     = (w_src != SRC_IDLE);

  fp_wb_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_b_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (Fifo_Count)
  );

  // Pick this cycle's write source; a starved head overrides port A.
  always_comb begin
    w_src = SRC_IDLE;
    if (!w_empty && (r_wait == SW'(STARVE))) begin
      w_src = SRC_FORCE;
    end else if (A_Valid) begin
      w_src = SRC_A;
    end else if (!w_empty) begin
      w_src = SRC_POP;
    end else begin
      w_src = SRC_IDLE;
    end
  end

  // Selected entry, FIFO pop and next starvation count.
  always_comb begin
    w_sel      = w_head;
    w_pop      = 1'b0;
    w_wait_nxt = {SW{1'b0}};
    case (w_src)
      SRC_FORCE, SRC_POP: begin
        w_pop      = 1'b1;
        w_wait_nxt = {SW{1'b0}};
      end
      SRC_A: begin
        w_sel.rd   = A_Rd;
        w_sel.data = A_Data;
        if (w_empty) begin
          w_wait_nxt = {SW{1'b0}};
        end else if (r_wait == SW'(STARVE)) begin
          w_wait_nxt = r_wait;
        end else begin
          w_wait_nxt = r_wait + SW'(1);
        end
      end
      SRC_IDLE: begin
        w_wait_nxt = {SW{1'b0}};
      end
      default: begin
        w_wait_nxt = {SW{1'b0}};
      end
    endcase
  end

  // Starvation counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wait <= {SW{1'b0}};
    end else begin
      r_wait <= w_wait_nxt;
    end
  end

  // Register-file write port; r0 is consumed but never written.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_reg_wr <= 1'b0;
      r_rd_wr  <= {WID_IN{1'b0}};
      r_rd_in  <= {WIDTH{1'b0}};
    end else begin
      r_reg_wr <= w_write && (w_sel.rd != {WID_IN{1'b0}});
      if (w_write) begin
        r_rd_wr <= w_sel.rd;
        r_rd_in <= w_sel.data;
      end
    end
  end

  assign Reg_Wr = r_reg_wr;
  assign Rd_Wr  = r_rd_wr;
  assign Rd_In  = r_rd_in;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Self-checking bench for fp_wb_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fp_wb_arbiter;

  localparam int WIDTH  = 32;
  localparam int WID_IN = 5;
  localparam int DEPTH  = 4;
  localparam int STARVE = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              A_Valid = 1'b0;
  logic              A_Ready;
  logic [WID_IN-1:0] A_Rd = '0;
  logic [WIDTH-1:0]  A_Data = '0;
  logic              B_Valid = 1'b0;
  logic              B_Ready;
  logic [WID_IN-1:0] B_Rd = '0;
  logic [WIDTH-1:0]  B_Data = '0;
  logic              Reg_Wr;
  logic [WID_IN-1:0] Rd_Wr;
  logic [WIDTH-1:0]  Rd_In;
  logic [2:0]        Fifo_Count;

  int n_checks = 0;
  int n_pass   = 0;

  fp_wb_arbiter dut (
    .CLK(CLK), .RST(RST),
    .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Rd(A_Rd), .A_Data(A_Data),
    .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Rd(B_Rd), .B_Data(B_Data),
    .Reg_Wr(Reg_Wr), .Rd_Wr(Rd_Wr), .Rd_In(Rd_In), .Fifo_Count(Fifo_Count)
  );

  always #5 CLK = ~CLK;

  // Reference model: pending B results, bypass count, expected write port.
  typedef struct {
    logic [WID_IN-1:0] rd;
    logic [WIDTH-1:0]  data;
  } ent_t;

  ent_t              mq[$];
  int                m_wait;
  logic              m_wr;
  logic [WID_IN-1:0] m_rd;
  logic [WIDTH-1:0]  m_data;

  function automatic bit m_aready();
    return !((mq.size() > 0) && (m_wait == STARVE));
  endfunction

  function automatic bit m_bready();
    return mq.size() != DEPTH;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wait = 0;
    m_wr   = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  task automatic model_eval();
    ent_t e;
    ent_t b;
    bit   have;
    bit   bacc;
    int   qs;
    have = 1'b0;
    qs   = mq.size();
    bacc = B_Valid && (qs != DEPTH);
    if ((qs > 0) && (m_wait == STARVE)) begin
      e = mq.pop_front(); have = 1'b1; m_wait = 0;
    end else if (A_Valid) begin
      e.rd = A_Rd; e.data = A_Data; have = 1'b1;
      if (qs > 0) begin
        if (m_wait < STARVE) m_wait++;
      end else m_wait = 0;
    end else if (qs > 0) begin
      e = mq.pop_front(); have = 1'b1; m_wait = 0;
    end else m_wait = 0;
    if (bacc) begin
      b.rd = B_Rd; b.data = B_Data; mq.push_back(b);
    end
    m_wr = have && (e.rd != '0);
    if (have) begin
      m_rd = e.rd; m_data = e.data;
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    n_checks++; if (Reg_Wr !== 1'b0) $display("FAIL rst_reg_wr: got %0b exp 0", Reg_Wr); else n_pass++;
    n_checks++; if (Rd_Wr !== 5'd0) $display("FAIL rst_rd_wr: got %0d exp 0", Rd_Wr); else n_pass++;
    n_checks++; if (Rd_In !== 32'd0) $display("FAIL rst_rd_in: got %h exp 0", Rd_In); else n_pass++;
    n_checks++; if (Fifo_Count !== 3'd0) $display("FAIL rst_count: got %0d exp 0", Fifo_Count); else n_pass++;
    n_checks++; if (A_Ready !== 1'b1) $display("FAIL rst_a_ready: got %0b exp 1", A_Ready); else n_pass++;
    n_checks++; if (B_Ready !== 1'b1) $display("FAIL rst_b_ready: got %0b exp 1", B_Ready); else n_pass++;
    @(negedge CLK); RST = 1'b1;
    tick();
    // Mid-stream reset with two buffered entries.
    A_Valid = 1'b1; A_Rd = 5'd1; A_Data = 32'hA5A5_0001;
    B_Valid = 1'b1; B_Rd = 5'd2; B_Data = 32'hB5B5_0002;
    tick();
    B_Rd = 5'd3; B_Data = 32'hB5B5_0003;
    tick();
    n_checks++; if (Fifo_Count !== 3'd2) $display("FAIL mid_count_pre: got %0d exp 2", Fifo_Count); else n_pass++;
    n_checks++; if (Reg_Wr !== 1'b1) $display("FAIL mid_wr_pre: got %0b exp 1", Reg_Wr); else n_pass++;
    #1; RST = 1'b0; #1;
    model_reset();
    A_Valid = 1'b0; B_Valid = 1'b0;
    n_checks++; if (Reg_Wr !== 1'b0) $display("FAIL mid_reg_wr: got %0b exp 0", Reg_Wr); else n_pass++;
    n_checks++; if (Rd_Wr !== 5'd0) $display("FAIL mid_rd_wr: got %0d exp 0", Rd_Wr); else n_pass++;
    n_checks++; if (Rd_In !== 32'd0) $display("FAIL mid_rd_in: got %h exp 0", Rd_In); else n_pass++;
    n_checks++; if (Fifo_Count !== 3'd0) $display("FAIL mid_count: got %0d exp 0", Fifo_Count); else n_pass++;
    n_checks++; if (A_Ready !== 1'b1) $display("FAIL mid_a_ready: got %0b exp 1", A_Ready); else n_pass++;
    n_checks++; if (B_Ready !== 1'b1) $display("FAIL mid_b_ready: got %0b exp 1", B_Ready); else n_pass++;
    @(negedge CLK); RST = 1'b1;
    tick();
  endtask

  task automatic test_a_only();
    A_Valid = 1'b1; A_Rd = 5'd3; A_Data = 32'h3F80_0000;
    tick();
    A_Valid = 1'b0;
    n_checks++; if (Reg_Wr !== 1'b1) $display("FAIL a_only_wr: got %0b exp 1", Reg_Wr); else n_pass++;
    n_checks++; if (Rd_Wr !== 5'd3) $display("FAIL a_only_rd: got %0d exp 3", Rd_Wr); else n_pass++;
    n_checks++; if (Rd_In !== 32'h3F80_0000) $display("FAIL a_only_data: got %h exp 3f800000", Rd_In); else n_pass++;
    tick();
    n_checks++; if (Reg_Wr !== 1'b0) $display("FAIL a_only_drop: got %0b exp 0", Reg_Wr); else n_pass++;
  endtask

  task automatic test_b_only();
    B_Valid = 1'b1; B_Rd = 5'd7; B_Data = 32'h4049_0FDB;
    tick();
    B_Valid = 1'b0;
    n_checks++; if (Fifo_Count !== 3'd1) $display("FAIL b_only_count1: got %0d exp 1", Fifo_Count); else n_pass++;
    n_checks++; if (Reg_Wr !== 1'b0) $display("FAIL b_only_nowr: got %0b exp 0", Reg_Wr); else n_pass++;
    tick();
    n_checks++; if (Reg_Wr !== 1'b1) $display("FAIL b_only_wr: got %0b exp 1", Reg_Wr); else n_pass++;
    n_checks++; if (Rd_Wr !== 5'd7) $display("FAIL b_only_rd: got %0d exp 7", Rd_Wr); else n_pass++;
    n_checks++; if (Rd_In !== 32'h4049_0FDB) $display("FAIL b_only_data: got %h exp 40490fdb", Rd_In); else n_pass++;
    n_checks++; if (Fifo_Count !== 3'd0) $display("FAIL b_only_count0: got %0d exp 0", Fifo_Count); else n_pass++;
  endtask

  task automatic test_starvation();
    A_Valid = 1'b1; A_Rd = 5'd9; A_Data = 32'h1111_0000;
    B_Valid = 1'b1; B_Rd = 5'd5; B_Data = 32'h5555_5555;
    tick();
    B_Valid = 1'b0;
    for (int i = 1; i <= STARVE; i++) begin
      n_checks++; if (A_Ready !== 1'b1) $display("FAIL starve_aready_%0d: got %0b exp 1", i, A_Ready); else n_pass++;
      tick();
      n_checks++; if (Reg_Wr !== 1'b1 || Rd_Wr !== 5'd9) $display("FAIL starve_a_%0d: got wr=%0b rd=%0d exp wr=1 rd=9", i, Reg_Wr, Rd_Wr); else n_pass++;
    end
    n_checks++; if (A_Ready !== 1'b0) $display("FAIL starve_force_aready: got %0b exp 0", A_Ready); else n_pass++;
    tick();
    n_checks++; if (Reg_Wr !== 1'b1 || Rd_Wr !== 5'd5 || Rd_In !== 32'h5555_5555) $display("FAIL starve_pop: got wr=%0b rd=%0d data=%h exp wr=1 rd=5 data=55555555", Reg_Wr, Rd_Wr, Rd_In); else n_pass++;
    n_checks++; if (A_Ready !== 1'b1) $display("FAIL starve_resume_aready: got %0b exp 1", A_Ready); else n_pass++;
    tick();
    A_Valid = 1'b0;
    n_checks++; if (Rd_Wr !== 5'd9 || Rd_In !== 32'h1111_0000) $display("FAIL starve_resume: got rd=%0d data=%h exp rd=9 data=11110000", Rd_Wr, Rd_In); else n_pass++;
  endtask

  task automatic test_full();
    A_Valid = 1'b1; A_Rd = 5'd20; A_Data = 32'h2020_2020;
    for (int i = 0; i < DEPTH; i++) begin
      B_Valid = 1'b1; B_Rd = 5'(10 + i); B_Data = 32'hB000_0000 + 32'(i);
      tick();
    end
    B_Rd = 5'd14; B_Data = 32'hB000_0004;
    n_checks++; if (Fifo_Count !== 3'd4) $display("FAIL full_count4: got %0d exp 4", Fifo_Count); else n_pass++;
    n_checks++; if (B_Ready !== 1'b0) $display("FAIL full_bready0: got %0b exp 0", B_Ready); else n_pass++;
    n_checks++; if (A_Ready !== 1'b0) $display("FAIL full_force: got %0b exp 0", A_Ready); else n_pass++;
    tick();
    n_checks++; if (Rd_Wr !== 5'd10 || Fifo_Count !== 3'd3) $display("FAIL full_pop0: got rd=%0d cnt=%0d exp rd=10 cnt=3", Rd_Wr, Fifo_Count); else n_pass++;
    n_checks++; if (B_Ready !== 1'b1) $display("FAIL full_bready1: got %0b exp 1", B_Ready); else n_pass++;
    tick();
    B_Valid = 1'b0; A_Valid = 1'b0;
    n_checks++; if (Fifo_Count !== 3'd4 || Rd_Wr !== 5'd20) $display("FAIL full_fifth: got cnt=%0d rd=%0d exp cnt=4 rd=20", Fifo_Count, Rd_Wr); else n_pass++;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      n_checks++;
      if (Reg_Wr !== 1'b1 || Rd_Wr !== 5'(10 + i) || Rd_In !== 32'hB000_0000 + 32'(i))
        $display("FAIL full_order_%0d: got wr=%0b rd=%0d data=%h exp wr=1 rd=%0d data=%h", i, Reg_Wr, Rd_Wr, Rd_In, 10 + i, 32'hB000_0000 + 32'(i));
      else n_pass++;
    end
    n_checks++; if (Fifo_Count !== 3'd0) $display("FAIL full_drained: got %0d exp 0", Fifo_Count); else n_pass++;
  endtask

  task automatic test_reg0();
    A_Valid = 1'b1; A_Rd = 5'd0; A_Data = 32'hDEAD_BEEF;
    n_checks++; if (A_Ready !== 1'b1) $display("FAIL r0_a_ready: got %0b exp 1", A_Ready); else n_pass++;
    tick();
    A_Valid = 1'b0;
    n_checks++; if (Reg_Wr !== 1'b0 || Rd_In !== 32'hDEAD_BEEF) $display("FAIL r0_a: got wr=%0b data=%h exp wr=0 data=deadbeef", Reg_Wr, Rd_In); else n_pass++;
    B_Valid = 1'b1; B_Rd = 5'd0; B_Data = 32'h1234_5678;
    tick();
    B_Valid = 1'b0;
    n_checks++; if (Fifo_Count !== 3'd1) $display("FAIL r0_b_count1: got %0d exp 1", Fifo_Count); else n_pass++;
    tick();
    n_checks++; if (Reg_Wr !== 1'b0 || Fifo_Count !== 3'd0 || Rd_In !== 32'h1234_5678) $display("FAIL r0_b: got wr=%0b cnt=%0d data=%h exp wr=0 cnt=0 data=12345678", Reg_Wr, Fifo_Count, Rd_In); else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      A_Valid = ($urandom_range(0, 9) < 7);
      A_Rd    = 5'($urandom_range(0, 31));
      A_Data  = $urandom;
      B_Valid = ($urandom_range(0, 1) == 1);
      B_Rd    = 5'($urandom_range(0, 31));
      B_Data  = $urandom;
      #1;
      n_checks++;
      if (A_Ready !== m_aready() || B_Ready !== m_bready() || Fifo_Count !== 3'(mq.size())) begin
        if (errs < 10) $display("FAIL rnd_ctrl c=%0d: got ar=%0b br=%0b cnt=%0d exp ar=%0b br=%0b cnt=%0d", c, A_Ready, B_Ready, Fifo_Count, m_aready(), m_bready(), mq.size());
        errs++;
      end else n_pass++;
      tick();
      n_checks++;
      if (Reg_Wr !== m_wr || (m_wr && (Rd_Wr !== m_rd || Rd_In !== m_data))) begin
        if (errs < 10) $display("FAIL rnd_write c=%0d: got wr=%0b rd=%0d data=%h exp wr=%0b rd=%0d data=%h", c, Reg_Wr, Rd_Wr, Rd_In, m_wr, m_rd, m_data);
        errs++;
      end else n_pass++;
    end
    A_Valid = 1'b0; B_Valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_b_only();
    test_starvation();
    test_full();
    test_reg0();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_wb_arbiter.md
# fp_wb_arbiter

Writeback arbiter for the floating-point register file (FReg_File). It collects results from two FP producers and drives the register file's single write port (Reg_Wr, Rd_Wr, Rd_In):
- **Port A:** the single-cycle FP ALU, which has priority.
- **Port B:** the long-latency FP divide/sqrt unit, buffered in a FIFO.

A starvation counter makes sure buffered port-B results are eventually written while port A is saturated.

## Interface
- WIDTH, 32, data width of a register value
- WID_IN, 5, register index width
- DEPTH, 4, port-B FIFO depth (power of 2, ≥2)
- STARVE, 3, cycles a non-empty FIFO head may be bypassed before a forced pop
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-low
- A_Valid  in  1  port-A result valid
- A_Ready  out  1  port-A accept
- A_Rd  in  WID_IN  port-A destination register
- A_Data  in  WIDTH  port-A result
- B_Valid  in  1  port-B result valid
- B_Ready  out  1  port-B accept
- B_Rd  in  WID_IN  port-B destination register
- B_Data  in  WIDTH  port-B result
- Reg_Wr  out  1  register-file write enable (registered)
- Rd_Wr  out  WID_IN  register-file write index (registered)
- Rd_In  out  WIDTH  register-file write data (registered)
- Fifo_Count  out  clog2(DEPTH)+1  entries held in the port-B FIFO

## Operation
- **Transfer rule:** a transfer occurs on a port at a rising edge where Valid && Ready.
- **Port B:**
  - B_Ready = (Fifo_Count != DEPTH), combinational from the count.
  - An accepted B result is pushed into the FIFO. It is never written directly.
- **Per-cycle write source**, decided combinationally, exactly one:
  - **Forced pop:** the FIFO is non-empty and wait_cnt == STARVE. A_Ready = 0, the FIFO head is popped, and wait_cnt is cleared to 0.
  - **A win:** else if A_Valid, port A is written (A_Ready = 1). If the FIFO is non-empty, wait_cnt increments.
  - **Idle pop:** else if the FIFO is non-empty, the head is popped and wait_cnt is cleared.
  - **Idle:** else Reg_Wr = 0 next cycle.
- A_Ready = 1 in every cycle except a forced-pop cycle.
- wait_cnt is saturating, width clog2(STARVE+1). It is cleared whenever the FIFO is empty.
- **Register 0:**
  - A selected entry with Rd == 0 is consumed normally (handshake or pop completes).
  - The registered Reg_Wr is 0 for that slot. Rd_Wr/Rd_In still update.
- **Simultaneous push and pop:** Fifo_Count is unchanged, and the FIFO pointers wrap modulo DEPTH.
- **Full FIFO:** when Fifo_Count == DEPTH, B_Ready = 0 even if a pop happens in the same cycle. No push-on-full.
- **Reset:**
  - Asserting RST at any time clears the FIFO (pointers and count to 0), wait_cnt, Reg_Wr, Rd_Wr and Rd_In to 0.
  - In-flight entries are discarded.

## Timing
- **Reset values:** Reg_Wr=0, Rd_Wr=0, Rd_In=0, Fifo_Count=0, A_Ready=1, B_Ready=1.
- **Port-A latency:** accepted at edge k, then Reg_Wr/Rd_Wr/Rd_In are valid after edge k (1 cycle).
- **Port-B latency:**
  - Pushed at edge k, popped at edge k+1 at the earliest, visible after edge k+1 (2 cycles).
  - The worst case under saturated A is k+STARVE+1 for the FIFO head.
- **Output duration:** Reg_Wr is high for exactly one cycle per written entry. Back-to-back writes are allowed every cycle.
- **Count update:** Fifo_Count updates on the same edge as the push or pop.

## Structure
- **Package fp_wb_pkg:** WIDTH, WID_IN and DEPTH defaults, plus a wb_entry_t typedef {rd[WID_IN-1:0], data[WIDTH-1:0]}.
- **Sub-module fp_wb_fifo:** a synchronous FIFO of wb_entry_t. It has push/pop/full/empty/count and wraps at DEPTH.
- **Top level:** arbitration, wait_cnt and the output registers.

## Test plan
- **Reset:** assert RST low mid-stream with 2 entries in the FIFO → all outputs 0 immediately, Fifo_Count=0, A_Ready=1, B_Ready=1.
- **A only:** A_Valid, A_Rd=3, A_Data=0x3F800000 at edge k → after k, Reg_Wr=1, Rd_Wr=3, Rd_In=0x3F800000. Reg_Wr=0 after k+1 if A_Valid drops.
- **B only:** B_Rd=7, B_Data=0x40490FDB pushed at edge k, A idle → Fifo_Count=1 after k. Reg_Wr=1, Rd_Wr=7 after k+1, and Fifo_Count=0.
- **Starvation:** A_Valid held high, one B entry (rd=5) pushed at k → A written at k+1..k+3. A_Ready=0 in the cycle before k+4. Rd_Wr=5 after k+4, and A resumes after k+5.
- **Full:**
  - With A saturated, push 4 B entries → B_Ready=0 once Fifo_Count=4. The 5th B stays held.
  - The forced pop drains one entry. The 5th B is accepted the cycle after that.
  - Pops preserve order across pointer wrap.
- **Register 0:** A_Rd=0, A_Data=0xDEADBEEF → handshake completes, Reg_Wr stays 0. The same check applies to a B entry with rd=0 (Fifo_Count decrements, no write).
